// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the fetch unit and the control decoder: default
//   field widths and the fetch-state encodings.
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam int FETCH_ADDR_W = 4;
  localparam int FETCH_DATA_W = 8;
  localparam int FETCH_OPC_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    READ = ST_READ,
    HOLD = ST_HOLD
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_ir_reg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_ir_reg
//   Instruction register: load-enabled DATA_W register with asynchronous
//   active-low clear, split into opcode (high bits) and operand (low bits).
// Ports
//   CLK      in   clock, rising edge
//   RESET_n  in   asynchronous active-low clear
//   load     in   capture d on this edge
//   d        in   instruction word
//   opcode   out  IR[DATA_W-1 -: OPC_W]
//   operand  out  IR[DATA_W-OPC_W-1:0]
// ---------------------------------------------------------------------------
module instruction_fetch_unit_ir_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DATA_W = FETCH_DATA_W,
  parameter int OPC_W  = FETCH_OPC_W
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       d,
  output logic [OPC_W-1:0]        opcode,
  output logic [DATA_W-OPC_W-1:0] operand
);

  logic [DATA_W-1:0] ir;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ir <= '0;
    end else if (load) begin
      ir <= d;
    end
  end

  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[DATA_W-OPC_W-1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetches the word addressed by the program counter, holds it in the IR
//   until the decoder accepts it, and pulses pc_inc once per completed fetch.
// Ports
//   CLK, RESET_n    clock (rising) / asynchronous active-low reset
//   pc_value        current program counter value
//   pc_inc          one-cycle pulse: advance the program counter
//   mem_addr        registered program memory address
//   mem_rd          read request, high in READ until mem_ack
//   mem_rdata       read data, valid with mem_ack
//   mem_ack         one-cycle read completion
//   ir_valid        IR holds an undelivered instruction
//   ir_ready        decoder accepts the IR this cycle
//   opcode/operand  IR fields
//   flush           discard in-flight fetch and IR
//   halt            stop issuing new fetches
//   busy            fetch FSM is not idle
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int OPC_W  = FETCH_OPC_W
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [ADDR_W-1:0]       pc_value,
  output logic                    pc_inc,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    ir_valid,
  input  logic                    ir_ready,
  output logic [OPC_W-1:0]        opcode,
  output logic [DATA_W-OPC_W-1:0] operand,
  input  logic                    flush,
  input  logic                    halt,
  output logic                    busy
);

  fetch_state_t state, state_next;
  logic         flush_pend, flush_pend_next;
  logic         load_addr;

  // State, pending-flush flag and the registered memory address.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
      if (load_addr) begin
        mem_addr <= pc_value;
      end
    end
  end

  // Next-state and output logic. A flush seen in READ cannot abort the
  // memory access, so it is remembered and the returning data is dropped;
  // a flush arriving together with the ack is treated the same way.
  always_comb begin
    state_next      = state;
    flush_pend_next = flush_pend;
    load_addr       = 1'b0;
    mem_rd          = 1'b0;
    pc_inc          = 1'b0;
    case (state)
      IDLE: begin
        if (!halt) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        load_addr  = 1'b1;
        state_next = flush ? ADDR : READ;
      end
      READ: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          if (flush_pend || flush) begin
            flush_pend_next = 1'b0;
            state_next      = ADDR;
          end else begin
            pc_inc     = 1'b1;
            state_next = HOLD;
          end
        end else if (flush) begin
          flush_pend_next = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = ADDR;
        end else if (ir_ready) begin
          state_next = halt ? IDLE : ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ir_valid = (state == HOLD);
  assign busy     = (state != IDLE);

  // The IR only loads on an accepted (non-flushed) ack, i.e. with pc_inc.
  instruction_fetch_unit_ir_reg #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_ir_reg (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .load    (pc_inc),
    .d       (mem_rdata),
    .opcode  (opcode),
    .operand (operand)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. Inputs change on the falling
//   edge, outputs are sampled on the falling edge (or just after an input
//   change for combinational outputs).
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic       CLK;
  logic       RESET_n;
  logic [3:0] pc_value;
  logic       pc_inc;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       ir_valid;
  logic       ir_ready;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       flush;
  logic       halt;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;
  int incCount   = 0;
  int rdCount    = 0;
  int incSnap;
  int rdSnap;

  instruction_fetch_unit dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .pc_value  (pc_value),
    .pc_inc    (pc_inc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .opcode    (opcode),
    .operand   (operand),
    .flush     (flush),
    .halt      (halt),
    .busy      (busy)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count pc_inc pulses and cycles with mem_rd high, as seen by each edge.
  always @(posedge CLK) begin
    if (pc_inc) incCount <= incCount + 1;
    if (mem_rd) rdCount  <= rdCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pc, input logic ack,
                               input logic [7:0] rdata, input logic fl,
                               input logic rdy, input logic hl);
    pc_value  = pc;
    mem_ack   = ack;
    mem_rdata = rdata;
    flush     = fl;
    ir_ready  = rdy;
    halt      = hl;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    RESET_n = 1'b0;
    applyStimulus(4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); tick();

    // Reset state.
    checkOutput("rst_busy",     busy,     0);
    checkOutput("rst_mem_rd",   mem_rd,   0);
    checkOutput("rst_ir_valid", ir_valid, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_opcode",   opcode,   0);
    checkOutput("rst_operand",  operand,  0);
    checkOutput("rst_pc_inc",   pc_inc,   0);

    // Basic fetch at pc=3, ack in first READ cycle.
    RESET_n = 1'b1;
    applyStimulus(4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    incSnap = incCount;
    tick();  // ADDR
    checkOutput("f1_addr_busy",  busy,     1);
    checkOutput("f1_addr_rd",    mem_rd,   0);
    checkOutput("f1_addr_valid", ir_valid, 0);
    tick();  // READ
    checkOutput("f1_read_rd",    mem_rd,   1);
    checkOutput("f1_mem_addr",   mem_addr, 3);
    checkOutput("f1_noack_inc",  pc_inc,   0);
    applyStimulus(4'd3, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("f1_ack_inc", pc_inc,   1);
    tick();  // HOLD, third edge after IDLE exit
    applyStimulus(4'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("f1_ir_valid",   ir_valid, 1);
    checkOutput("f1_opcode",     opcode,   4'hA);
    checkOutput("f1_operand",    operand,  4'h5);
    checkOutput("f1_hold_rd",    mem_rd,   0);
    checkOutput("f1_inc_count",  incCount - incSnap, 1);

    // Ack delayed to the 4th READ cycle.
    tick();  // ADDR
    applyStimulus(4'd7, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("f2_valid_drop", ir_valid, 0);
    incSnap = incCount;
    rdSnap  = rdCount;
    for (int i = 0; i < 3; i++) begin
      tick();  // READ, no ack
      checkOutput("f2_wait_rd",     mem_rd, 1);
      checkOutput("f2_wait_opcode", opcode, 4'hA);
    end
    tick();  // 4th READ cycle
    applyStimulus(4'd7, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
    tick();  // HOLD
    applyStimulus(4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("f2_rd_cycles",  rdCount - rdSnap, 4);
    checkOutput("f2_inc_count",  incCount - incSnap, 1);
    checkOutput("f2_opcode",     opcode,   4'h9);
    checkOutput("f2_operand",    operand,  4'h6);
    checkOutput("f2_mem_addr",   mem_addr, 7);

    // Decoder stalls for 5 cycles in HOLD.
    incSnap = incCount;
    rdSnap  = rdCount;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("f3_valid",  ir_valid, 1);
      checkOutput("f3_opcode", opcode,   4'h9);
      checkOutput("f3_rd",     mem_rd,   0);
    end
    checkOutput("f3_no_inc", incCount - incSnap, 0);
    checkOutput("f3_no_rd",  rdCount - rdSnap,   0);

    // Flush during READ; ack two cycles later is dropped.
    applyStimulus(4'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();  // ADDR
    applyStimulus(4'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();  // READ
    checkOutput("f4_mem_addr", mem_addr, 2);
    incSnap = incCount;
    applyStimulus(4'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();  // READ, flush pending
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("f4_rd_held", mem_rd, 1);
    tick();  // READ, ack arrives two cycles after the flush
    applyStimulus(4'd9, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("f4_ack_no_inc", pc_inc, 0);
    tick();  // ADDR
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("f4_valid",    ir_valid, 0);
    checkOutput("f4_busy",     busy,     1);
    tick();  // READ at new pc
    checkOutput("f4_new_addr", mem_addr, 9);
    checkOutput("f4_new_rd",   mem_rd,   1);
    checkOutput("f4_opcode",   opcode,   4'h9);
    checkOutput("f4_no_inc",   incCount - incSnap, 0);

    // Complete the fetch, then halt at HOLD exit.
    applyStimulus(4'd9, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    tick();  // HOLD
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("f5_valid",   ir_valid, 1);
    checkOutput("f5_opcode",  opcode,   4'h1);
    tick();  // IDLE
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    rdSnap = rdCount;
    for (int i = 0; i < 3; i++) begin
      checkOutput("f5_idle_busy", busy,   0);
      checkOutput("f5_idle_rd",   mem_rd, 0);
      tick();
    end
    checkOutput("f5_no_rd", rdCount - rdSnap, 0);
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();  // ADDR
    tick();  // READ
    checkOutput("f5_resume_rd", mem_rd, 1);

    // Asynchronous reset in the middle of READ, then a stray ack.
    #2 RESET_n = 1'b0;
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("r_mem_rd",   mem_rd,   0);
    checkOutput("r_busy",     busy,     0);
    checkOutput("r_valid",    ir_valid, 0);
    checkOutput("r_mem_addr", mem_addr, 0);
    checkOutput("r_opcode",   opcode,   0);
    checkOutput("r_pc_inc",   pc_inc,   0);
    tick();
    RESET_n = 1'b1;
    incSnap = incCount;
    applyStimulus(4'd9, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("r_stray_inc", pc_inc, 0);
    tick();
    applyStimulus(4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("r_stray_valid",  ir_valid, 0);
    checkOutput("r_stray_opcode", opcode,   0);
    checkOutput("r_stray_busy",   busy,     0);
    checkOutput("r_stray_count",  incCount - incSnap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
